data_launch_1s: RTL and testbench
=================================

# data_launch_1s

Source-domain launcher feeding the single-clock destination data synchronizer. Accepts words over a valid/ready handshake and drives `data_s` across the clock boundary, holding each word stable long enough for the destination synchronizer stages and filter to qualify it. A one-entry pending buffer absorbs a push that arrives while a word is still held. Sits in the source clock domain, directly upstream of the destination synchronizer's `data_s` input.

## Interface
- `width`, 8, data word width (1..1024)
- `f_sync_type`, 2, destination synchronizer depth to cover (0..4; 0 = no sync stages)
- `filt_size`, 1, width of the destination filter field; sizes `hold_s`

Ports:
- `clk_s`  in  1  source clock; all logic rising-edge
- `rst_s`  in  1  asynchronous, active-high reset
- `init_s_n`  in  1  synchronous active-low clear; same effect as reset; overrides `push_s`
- `push_s`  in  1  request to launch `data_in_s`; accepted when `push_s && ready_s`
- `data_in_s`  in  width  word to launch
- `hold_s`  in  filt_size+1  extra hold cycles; match the destination `filt_d` setting
- `ready_s`  out  1  pending buffer empty; a push is accepted
- `data_s`  out  width  registered word driven to the destination synchronizer
- `launch_s`  out  1  one-cycle pulse in the first cycle a new word is on `data_s`
- `busy_s`  out  1  high while in HOLD
- `ovf_s`  out  1  sticky: a push was presented while `ready_s` was low

## Operation
- Hold length H = `hold_s` + `f_sync_type` + 1 cycles. Sample `hold_s` when a word is loaded into `data_s`; changes mid-hold have no effect.
- States:
  - IDLE: `busy_s`=0. An accepted push loads `data_s`, loads the counter with H-1, and moves to HOLD.
  - HOLD: the counter decrements each cycle. When the counter is 0 (last hold cycle):
    - pending valid: load the pending word into `data_s`, reload the counter, stay in HOLD;
    - push accepted in this same cycle: load `data_in_s` directly (bypass), reload, stay in HOLD;
    - otherwise: go to IDLE.
- Pending buffer, one entry: an accepted push in HOLD with counter != 0 writes `data_in_s` into pending. `ready_s` = !pending_valid.
- A push while `ready_s`=0 is dropped and sets `ovf_s`. Only reset or `init_s_n` clears `ovf_s`.
- `launch_s` pulses on every load, including a word equal to the previous one.
- `data_s` changes only on a load. It never changes during a hold window.

## Timing
- Reset and init values: `data_s`=0, `ready_s`=1, `launch_s`=0, `busy_s`=0, `ovf_s`=0, state IDLE, pending empty, counter 0.
- Reset is asynchronous. Asserting `rst_s` mid-HOLD discards the held word and the pending word immediately.
- `init_s_n` low at edge n: all registers take their reset values at n+1. A push in the same cycle is ignored and does not set `ovf_s`.
- Latency: a push accepted in IDLE at edge n gives new `data_s` and `launch_s`=1 at n+1, and `busy_s`=1 from n+1 through n+H.
- Back-to-back: the next load occurs exactly H cycles after the previous one (no dead cycle) when pending is valid or a bypass push arrives.
- Counter width: filt_size+3 bits. No wrap-around is possible for legal parameters.

## Structure
- Package `data_launch_pkg`:
  - state enum {IDLE, HOLD};
  - function `hold_len(hold_s, f_sync_type)`;
  - counter-width constant.
- Sub-module `data_launch_hold_cnt`: loadable down-counter with `load`, `load_val`, and `zero` outputs.
- The top level holds the FSM, the pending register, `ovf_s`, and the output registers.

## Test plan
- Reset: assert `rst_s` mid-HOLD with pending full -> all outputs return to reset values immediately; `ready_s`=1 after release.
- Single launch: f_sync_type=2, hold_s=1 (H=4); push 0xA5 in IDLE at n -> `data_s`=0xA5 and `launch_s`=1 at n+1; `busy_s` high n+1..n+4; IDLE at n+5.
- Pending and back-to-back: push 0x11 at n, push 0x22 at n+2 -> `ready_s`=0 from n+3; `data_s`=0x22 with `launch_s` at n+5; `ready_s`=1 at n+5.
- Bypass: push 0x33 exactly in the last hold cycle with pending empty -> `data_s`=0x33 in the next cycle, and `ready_s` never drops.
- Overflow: pending full, push 0x44 -> 0x44 never appears on `data_s`; `ovf_s`=1 until `init_s_n` is pulsed low, then 0.
- Hold sampling: hold_s=3 at load, changed to 0 mid-hold -> hold stays H=6 (hold_s=3 + f_sync_type=2 + 1); `data_s` stable for all 6 cycles.

Source files
------------

// File: rtl/data_launch_pkg.sv
// Shared types and sizing helpers for the data_launch_1s source-domain launcher.
package data_launch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Hold counter needs filt_size+3 bits to cover the longest legal window.
    localparam int unsigned CNT_W_EXTRA = 3;

    function automatic int unsigned cnt_width(input int unsigned filt_size);
        return filt_size + CNT_W_EXTRA;
    endfunction

    function automatic int unsigned hold_len(input int unsigned hold_s,
                                             input int unsigned f_sync_type);
        return hold_s + f_sync_type + 1;
    endfunction

endpackage

// File: rtl/data_launch_hold_cnt.sv
// Loadable down-counter timing the hold window; saturates at zero.
module data_launch_hold_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_s,
    input  logic             rst_s,
    input  logic             clr_s,
    input  logic             load_s,
    input  logic [CNT_W-1:0] load_val_s,
    output logic             zero_s
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_s) begin
            cnt_d = '0;
        end else if (load_s) begin
            cnt_d = load_val_s;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_s = (cnt_q == '0);

endmodule

// File: rtl/data_launch_1s.sv
// Source-domain launcher: holds each word on data_s for H cycles so the
// destination synchronizer and filter can qualify it; one pending slot.
module data_launch_1s
    import data_launch_pkg::*;
#(
    parameter int unsigned width       = 8,
    parameter int unsigned f_sync_type = 2,
    parameter int unsigned filt_size   = 1
) (
    input  logic               clk_s,
    input  logic               rst_s,
    input  logic               init_s_n,
    input  logic               push_s,
    input  logic [width-1:0]   data_in_s,
    input  logic [filt_size:0] hold_s,
    output logic               ready_s,
    output logic [width-1:0]   data_s,
    output logic               launch_s,
    output logic               busy_s,
    output logic               ovf_s
);

    localparam int unsigned CNT_W = cnt_width(filt_size);

    state_e             state_q, state_d;
    logic [width-1:0]   data_q, data_d;
    logic [width-1:0]   pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               launch_q, launch_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               cnt_clr;
    logic               cnt_load;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_val;

    // Counter is loaded with H-1 so that zero marks the last hold cycle.
    assign cnt_val = CNT_W'(hold_len(32'(hold_s), f_sync_type) - 32'd1);
    assign cnt_clr = ~init_s_n;

    data_launch_hold_cnt #(
        .CNT_W(CNT_W)
    ) u_hold_cnt (
        .clk_s      (clk_s),
        .rst_s      (rst_s),
        .clr_s      (cnt_clr),
        .load_s     (cnt_load),
        .load_val_s (cnt_val),
        .zero_s     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        launch_d   = 1'b0;
        ovf_d      = ovf_q;
        cnt_load   = 1'b0;
        accept     = push_s && !pend_vld_q;

        if (!init_s_n) begin
            state_d    = IDLE;
            data_d     = '0;
            pend_d     = '0;
            pend_vld_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            if (push_s && pend_vld_q) begin
                ovf_d = 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_d   = data_in_s;
                        launch_d = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (!cnt_zero) begin
                        if (accept) begin
                            pend_d     = data_in_s;
                            pend_vld_d = 1'b1;
                        end
                    // Last hold cycle: pending word wins over a bypass push.
                    end else if (pend_vld_q) begin
                        data_d     = pend_q;
                        pend_vld_d = 1'b0;
                        launch_d   = 1'b1;
                        cnt_load   = 1'b1;
                    end else if (accept) begin
                        data_d   = data_in_s;
                        launch_d = 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            state_q    <= IDLE;
            data_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            launch_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            launch_q   <= launch_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ready_s  = ~pend_vld_q;
    assign data_s   = data_q;
    assign launch_s = launch_q;
    assign busy_s   = (state_q == HOLD);
    assign ovf_s    = ovf_q;

endmodule

// File: tb/tb_data_launch_1s.sv
// Self-checking bench for data_launch_1s: vector table, corner sequences and
// randomized traffic against a window/queue reference model.
module tb_data_launch_1s;

    localparam int unsigned W    = 8;
    localparam int unsigned FS   = 2;
    localparam int unsigned FILT = 1;

    logic          clk_s = 1'b0;
    logic          rst_s;
    logic          init_s_n;
    logic          push_s;
    logic [W-1:0]  data_in_s;
    logic [FILT:0] hold_s;
    logic          ready_s;
    logic [W-1:0]  data_s;
    logic          launch_s;
    logic          busy_s;
    logic          ovf_s;

    data_launch_1s #(
        .width       (W),
        .f_sync_type (FS),
        .filt_size   (FILT)
    ) dut (
        .clk_s     (clk_s),
        .rst_s     (rst_s),
        .init_s_n  (init_s_n),
        .push_s    (push_s),
        .data_in_s (data_in_s),
        .hold_s    (hold_s),
        .ready_s   (ready_s),
        .data_s    (data_s),
        .launch_s  (launch_s),
        .busy_s    (busy_s),
        .ovf_s     (ovf_s)
    );

    always #5 clk_s = ~clk_s;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: a word is held for a window of hold+FS+1 cycles,
    // counted up from its first visible cycle; pending words wait in a queue.
    logic [W-1:0] m_data;
    bit           m_launch;
    bit           m_busy;
    bit           m_ovf;
    int unsigned  m_elapsed;
    int unsigned  m_win;
    logic [W-1:0] m_pend[$];

    function automatic void m_reset();
        m_data    = '0;
        m_launch  = 1'b0;
        m_busy    = 1'b0;
        m_ovf     = 1'b0;
        m_elapsed = 0;
        m_win     = 0;
        m_pend.delete();
    endfunction

    function automatic void m_load(input logic [W-1:0] w, input int unsigned hold);
        m_data    = w;
        m_launch  = 1'b1;
        m_busy    = 1'b1;
        m_elapsed = 1;
        m_win     = hold + FS + 1;
    endfunction

    function automatic void m_step(input bit push, input logic [W-1:0] din,
                                   input int unsigned hold, input bit init);
        bit rdy;
        bit acc;
        if (!init) begin
            m_reset();
            return;
        end
        rdy = (m_pend.size() == 0);
        acc = push && rdy;
        if (push && !rdy) m_ovf = 1'b1;
        m_launch = 1'b0;
        if (!m_busy) begin
            if (acc) m_load(din, hold);
        end else if (m_elapsed == m_win) begin
            if (m_pend.size() != 0) m_load(m_pend.pop_front(), hold);
            else if (acc) m_load(din, hold);
            else m_busy = 1'b0;
        end else begin
            m_elapsed++;
            if (acc) m_pend.push_back(din);
        end
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_model();
        check("data_s",   32'(data_s),   32'(m_data));
        check("launch_s", 32'(launch_s), 32'(m_launch));
        check("busy_s",   32'(busy_s),   32'(m_busy));
        check("ready_s",  32'(ready_s),  32'(m_pend.size() == 0));
        check("ovf_s",    32'(ovf_s),    32'(m_ovf));
    endfunction

    task automatic cycle(input bit push, input logic [W-1:0] din,
                         input logic [FILT:0] hold, input bit init);
        push_s    = push;
        data_in_s = din;
        hold_s    = hold;
        init_s_n  = init;
        @(posedge clk_s);
        m_step(push, din, 32'(hold), init);
        #1;
    endtask

    typedef struct {
        bit           push;
        logic [W-1:0] din;
        bit           init;
        logic [W-1:0] e_data;
        bit           e_launch;
        bit           e_busy;
        bit           e_ready;
        bit           e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit p, input logic [W-1:0] d, input bit i,
                                input logic [W-1:0] ed, input bit el, input bit eb,
                                input bit er, input bit eo);
        vec_t v;
        v.push = p; v.din = d; v.init = i;
        v.e_data = ed; v.e_launch = el; v.e_busy = eb; v.e_ready = er; v.e_ovf = eo;
        tbl.push_back(v);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_s = 1'b1; init_s_n = 1'b1; push_s = 1'b0; data_in_s = '0; hold_s = '0;
        m_reset();
        repeat (2) @(posedge clk_s);
        #1;
        check("rst data_s",   32'(data_s),   32'h0);
        check("rst launch_s", 32'(launch_s), 32'h0);
        check("rst busy_s",   32'(busy_s),   32'h0);
        check("rst ready_s",  32'(ready_s),  32'h1);
        check("rst ovf_s",    32'(ovf_s),    32'h0);
        rst_s = 1'b0;

        // H = 4 throughout the table (hold_s = 1)
        add(1, 8'hA5, 1, 8'hA5, 1, 1, 1, 0);
        add(0, 8'h00, 1, 8'hA5, 0, 1, 1, 0);
        add(0, 8'h00, 1, 8'hA5, 0, 1, 1, 0);
        add(0, 8'h00, 1, 8'hA5, 0, 1, 1, 0);
        add(0, 8'h00, 1, 8'hA5, 0, 0, 1, 0);
        add(1, 8'h11, 1, 8'h11, 1, 1, 1, 0);
        add(0, 8'h00, 1, 8'h11, 0, 1, 1, 0);
        add(1, 8'h22, 1, 8'h11, 0, 1, 0, 0);
        add(0, 8'h00, 1, 8'h11, 0, 1, 0, 0);
        add(0, 8'h00, 1, 8'h22, 1, 1, 1, 0);
        add(0, 8'h00, 1, 8'h22, 0, 1, 1, 0);
        add(0, 8'h00, 1, 8'h22, 0, 1, 1, 0);
        add(0, 8'h00, 1, 8'h22, 0, 1, 1, 0);
        add(1, 8'h33, 1, 8'h33, 1, 1, 1, 0);
        add(1, 8'h55, 1, 8'h33, 0, 1, 0, 0);
        add(1, 8'h44, 1, 8'h33, 0, 1, 0, 1);
        add(0, 8'h00, 1, 8'h33, 0, 1, 0, 1);
        add(0, 8'h00, 1, 8'h55, 1, 1, 1, 1);
        add(0, 8'h00, 1, 8'h55, 0, 1, 1, 1);
        add(0, 8'h00, 1, 8'h55, 0, 1, 1, 1);
        add(0, 8'h00, 1, 8'h55, 0, 1, 1, 1);
        add(0, 8'h00, 1, 8'h55, 0, 0, 1, 1);
        add(1, 8'h66, 0, 8'h00, 0, 0, 1, 0);
        add(0, 8'h00, 1, 8'h00, 0, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].push, tbl[i].din, 2'd1, tbl[i].init);
            check($sformatf("tbl%0d data_s", i),   32'(data_s),   32'(tbl[i].e_data));
            check($sformatf("tbl%0d launch_s", i), 32'(launch_s), 32'(tbl[i].e_launch));
            check($sformatf("tbl%0d busy_s", i),   32'(busy_s),   32'(tbl[i].e_busy));
            check($sformatf("tbl%0d ready_s", i),  32'(ready_s),  32'(tbl[i].e_ready));
            check($sformatf("tbl%0d ovf_s", i),    32'(ovf_s),    32'(tbl[i].e_ovf));
        end

        // hold_s sampled at load: 3 -> H = 6 even though it drops to 0 mid-hold
        cycle(1, 8'h66, 2'd3, 1);
        check("hs launch", 32'(launch_s), 32'h1);
        for (int k = 1; k < 6; k++) begin
            cycle(0, 8'h00, 2'd0, 1);
            check($sformatf("hs busy%0d", k), 32'(busy_s), 32'h1);
            check($sformatf("hs data%0d", k), 32'(data_s), 32'h66);
            check_model();
        end
        cycle(0, 8'h00, 2'd0, 1);
        check("hs idle", 32'(busy_s), 32'h0);
        check_model();

        // asynchronous reset mid-hold with pending full and ovf set
        cycle(1, 8'h77, 2'd3, 1);
        cycle(1, 8'h88, 2'd3, 1);
        cycle(1, 8'h99, 2'd3, 1);
        check_model();
        check("pre-rst ovf", 32'(ovf_s), 32'h1);
        rst_s = 1'b1;
        #2;
        check("arst data_s",   32'(data_s),   32'h0);
        check("arst busy_s",   32'(busy_s),   32'h0);
        check("arst ready_s",  32'(ready_s),  32'h1);
        check("arst ovf_s",    32'(ovf_s),    32'h0);
        check("arst launch_s", 32'(launch_s), 32'h0);
        m_reset();
        rst_s = 1'b0;
        cycle(0, 8'h00, 2'd0, 1);
        check("post-rst ready", 32'(ready_s), 32'h1);
        check_model();

        // init with a push while pending is full: ignored, no overflow
        cycle(1, 8'hAA, 2'd2, 1);
        cycle(1, 8'hBB, 2'd2, 1);
        cycle(1, 8'hCC, 2'd2, 0);
        check("init ovf_s",  32'(ovf_s),  32'h0);
        check("init data_s", 32'(data_s), 32'h0);
        check("init busy_s", 32'(busy_s), 32'h0);
        check_model();

        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 99) < 45), W'($urandom),
                  (FILT + 1)'($urandom_range(0, 3)), ($urandom_range(0, 199) != 0));
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
